axis_output_pipe: RTL

- Receives the conv engine's wide result stream, one beat per cycle carrying CORES*UNITS words, and serializes each beat into narrower output-DMA beats.
- Sits at the output end of the datapath, mirroring the input pipe that fans DMA streams into the conv engine.
- Holds one conv beat in a register and emits it as N = (CORES*UNITS)/OUT_WORDS sub-beats, least-significant words first, with full AXI-Stream handshakes on both sides.

---
 rtl/axis_output_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/axis_output_pipe.sv
// Serializes each wide conv-engine result beat into N narrower output-DMA beats,
// least-significant words first, with full AXI-Stream handshakes on both sides.
module axis_output_pipe #(
   parameter int UNITS       = 2,
   parameter int CORES       = 4,
   parameter int WORD_WIDTH  = 8,
   parameter int OUT_WORDS   = 4,
   parameter int TUSER_WIDTH = 3
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tvalid,
   input  logic                                  s_axis_tlast,
   input  logic [WORD_WIDTH*CORES*UNITS-1:0]     s_axis_tdata,
   input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
   input  logic                                  m_axis_tready,
   output logic                                  m_axis_tvalid,
   output logic                                  m_axis_tlast,
   output logic [WORD_WIDTH*OUT_WORDS-1:0]       m_axis_tdata,
   output logic [WORD_WIDTH*OUT_WORDS/8-1:0]     m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]                m_axis_tuser
);

   localparam int IN_WORDS = CORES * UNITS;
   localparam int N        = IN_WORDS / OUT_WORDS;
   localparam int CNT_BITS = (N > 1) ? $clog2(N) : 1;
   localparam int IN_W     = WORD_WIDTH * IN_WORDS;
   localparam int OUT_W    = WORD_WIDTH * OUT_WORDS;

   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(N - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                state;
   logic                  full;
   logic [CNT_BITS-1:0]   cnt;
   logic [IN_W-1:0]       data_reg;
   logic                  last_reg;
   logic [TUSER_WIDTH-1:0] user_reg;

   logic                  final_sub;
   logic                  m_hs;
   logic                  s_hs;

   assign full      = (state == HOLD);
   assign final_sub = (cnt == CNT_LAST);
   assign m_hs      = full && m_axis_tready;

   // Ready only looks at held state and downstream ready, never at s_axis_tvalid,
   // so the last sub-beat and the next load can share a cycle without a bubble.
   assign s_axis_tready = !areset && (!full || (final_sub && m_axis_tready));
   assign s_hs          = s_axis_tvalid && s_axis_tready;

   assign m_axis_tvalid = full;
   assign m_axis_tlast  = full && last_reg && final_sub;
   assign m_axis_tuser  = user_reg;
   assign m_axis_tkeep  = '1;

   always_comb begin
      m_axis_tdata = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt == CNT_BITS'(i)) begin
            m_axis_tdata = data_reg[i*OUT_W +: OUT_W];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= EMPTY;
         cnt      <= '0;
         data_reg <= '0;
         last_reg <= 1'b0;
         user_reg <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (s_hs) begin
                  data_reg <= s_axis_tdata;
                  last_reg <= s_axis_tlast;
                  user_reg <= s_axis_tuser;
                  cnt      <= '0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (m_hs) begin
                  if (!final_sub) begin
                     cnt <= cnt + CNT_ONE;
                  end else if (s_hs) begin
                     data_reg <= s_axis_tdata;
                     last_reg <= s_axis_tlast;
                     user_reg <= s_axis_tuser;
                     cnt      <= '0;
                  end else begin
                     cnt   <= '0;
                     state <= EMPTY;
                  end
               end
            end
         endcase
      end
   end

endmodule
